// File: rtl/rnd_gen_if.sv
// Word-request bus between the execute stage (master) and the random word source (slave).
interface rnd_gen_if;
  logic        seed_load;
  logic [31:0] seed;
  logic        entropy_valid;
  logic        entropy_bit;
  logic        rnd_req;
  logic        rnd_valid;
  logic [31:0] rnd_out;
  logic        ready;

  modport master (
    output seed_load, seed, entropy_valid, entropy_bit, rnd_req,
    input  rnd_valid, rnd_out, ready
  );

  modport slave (
    input  seed_load, seed, entropy_valid, entropy_bit, rnd_req,
    output rnd_valid, rnd_out, ready
  );
endinterface

// File: rtl/rnd_gen.sv
// Galois LFSR pseudo-random word source for the AU rndin operand.
// The LFSR steps only during warm-up and on each delivered word, so every seed replays identically.
module rnd_gen #(
  parameter logic [31:0] SEED   = 32'h4655434B,
  parameter logic [31:0] POLY   = 32'h80200003,
  parameter int          WARMUP = 16
) (
  input logic       clk,
  input logic       rst,
  rnd_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    WARM = 2'b00,
    RUN  = 2'b01
  } state_t;

  localparam logic [7:0] WARM_LAST = 8'(WARMUP);

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [31:0] lfsr, lfsr_nxt, stepped;
  logic        step;
  logic        issue;

  // Entropy lands on the top bit; an all-zero result is replaced so the LFSR never locks up.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic ev, input logic eb);
    logic [31:0] n;
    n = {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    n[31] = n[31] ^ (ev & eb);
    if (n == 32'h0) n = SEED;
    return n;
  endfunction

  assign stepped = lfsr_step(lfsr, bus.entropy_valid, bus.entropy_bit);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lfsr_nxt  = lfsr;
    step      = 1'b0;
    issue     = 1'b0;
    if (bus.seed_load) begin
      lfsr_nxt  = (bus.seed == 32'h0) ? SEED : bus.seed;
      count_nxt = '0;
      state_nxt = WARM;
    end else begin
      case (state)
        RUN: begin
          if (bus.rnd_req) begin
            issue = 1'b1;
            step  = 1'b1;
          end
        end
        default: begin
          state_nxt = WARM;
          if (WARMUP == 0) begin
            state_nxt = RUN;
          end else begin
            step      = 1'b1;
            count_nxt = count + 8'd1;
            if (count_nxt == WARM_LAST) state_nxt = RUN;
          end
        end
      endcase
      if (step) lfsr_nxt = stepped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WARM;
      count         <= '0;
      lfsr          <= SEED;
      bus.rnd_valid <= 1'b0;
      bus.rnd_out   <= '0;
      bus.ready     <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      lfsr          <= lfsr_nxt;
      bus.rnd_valid <= issue;
      bus.ready     <= (state_nxt == RUN);
      if (issue) bus.rnd_out <= lfsr;
    end
  end

endmodule

// File: tb/tb_rnd_gen.sv
// Bench for rnd_gen: three warm-up depths driven in parallel, checked against a word-level model.
module tb_rnd_gen;

  localparam logic [31:0] SEED = 32'h4655434B;
  localparam logic [31:0] POLY = 32'h80200003;
  localparam int          WS [3] = '{0, 2, 16};

  logic        clk;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed;
  logic        ev;
  logic        eb;
  logic        req;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  o_valid, o_ready;
  logic [31:0] o_out [3];

  logic [31:0] wq0[$];
  logic [31:0] wq2[$];
  logic [31:0] wq16[$];

  // Model state: words-to-go before ready, current register, last delivered word.
  logic [31:0] m_lfsr  [3];
  int          m_left  [3];
  logic        m_run   [3];
  logic        m_valid [3];
  logic [31:0] m_out   [3];

  rnd_gen_if i0 ();
  rnd_gen_if i2 ();
  rnd_gen_if i16 ();

  assign i0.seed_load      = seed_load;  assign i2.seed_load      = seed_load;  assign i16.seed_load      = seed_load;
  assign i0.seed           = seed;       assign i2.seed           = seed;       assign i16.seed           = seed;
  assign i0.entropy_valid  = ev;         assign i2.entropy_valid  = ev;         assign i16.entropy_valid  = ev;
  assign i0.entropy_bit    = eb;         assign i2.entropy_bit    = eb;         assign i16.entropy_bit    = eb;
  assign i0.rnd_req        = req;        assign i2.rnd_req        = req;        assign i16.rnd_req        = req;

  assign o_valid = {i16.rnd_valid, i2.rnd_valid, i0.rnd_valid};
  assign o_ready = {i16.ready, i2.ready, i0.ready};
  assign o_out[0] = i0.rnd_out;
  assign o_out[1] = i2.rnd_out;
  assign o_out[2] = i16.rnd_out;

  rnd_gen #(.WARMUP(0))  dut0  (.clk(clk), .rst(rst), .bus(i0.slave));
  rnd_gen #(.WARMUP(2))  dut2  (.clk(clk), .rst(rst), .bus(i2.slave));
  rnd_gen                dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] nstep(input logic [31:0] s, input logic e_v, input logic e_b);
    logic [31:0] n;
    n = (s >> 1) ^ (s[0] ? POLY : 32'h0);
    if (e_v && e_b) n = n ^ 32'h8000_0000;
    if (n == 32'h0) n = SEED;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      logic [31:0] l;
      int          left;
      l    = m_lfsr[k];
      left = m_left[k];
      if (rst) begin
        m_lfsr[k]  <= SEED;
        m_left[k]  <= WS[k];
        m_run[k]   <= 1'b0;
        m_valid[k] <= 1'b0;
        m_out[k]   <= 32'h0;
      end else if (seed_load) begin
        m_lfsr[k]  <= (seed == 32'h0) ? SEED : seed;
        m_left[k]  <= WS[k];
        m_run[k]   <= 1'b0;
        m_valid[k] <= 1'b0;
      end else if (!m_run[k]) begin
        m_valid[k] <= 1'b0;
        if (left > 0) begin
          l    = nstep(l, ev, eb);
          left = left - 1;
        end
        m_lfsr[k] <= l;
        m_left[k] <= left;
        m_run[k]  <= (left == 0);
      end else if (req) begin
        m_out[k]   <= l;
        m_valid[k] <= 1'b1;
        m_lfsr[k]  <= nstep(l, ev, eb);
      end else begin
        m_valid[k] <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid_w%0d", WS[k]), {31'h0, o_valid[k]}, {31'h0, m_valid[k]});
      chk($sformatf("ready_w%0d", WS[k]), {31'h0, o_ready[k]}, {31'h0, m_run[k]});
      chk($sformatf("out_w%0d", WS[k]), o_out[k], m_out[k]);
    end
    if (o_valid[0]) wq0.push_back(o_out[0]);
    if (o_valid[1]) wq2.push_back(o_out[1]);
    if (o_valid[2]) wq16.push_back(o_out[2]);
  endtask

  // Loads a seed into all instances and checks the WARMUP=16 word stream against the expected sequence.
  task automatic run_seed(input string tag, input logic [31:0] s, input int n);
    logic [31:0] r;
    int edges;
    seed = s;
    seed_load = 1'b1;
    tick();
    chk({tag, "_novalid"}, {29'h0, o_valid}, 32'h0);
    chk({tag, "_notready"}, {29'h0, o_ready}, 32'h0);
    seed_load = 1'b0;
    req = 1'b1;
    edges = 1;
    wq16.delete();
    while (!o_ready[2] && edges < 64) begin
      tick();
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'd17);
    for (int i = 0; i < 64 && wq16.size() < n; i++) tick();
    req = 1'b0;
    r = (s == 32'h0) ? SEED : s;
    for (int i = 0; i < 16; i++) r = nstep(r, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_word%0d", tag, i), wq16[i], r);
      chk($sformatf("%s_nonzero%0d", tag, i), {31'h0, wq16[i] != 32'h0}, 32'h1);
      r = nstep(r, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = 32'h0; ev = 1'b0; eb = 1'b0; req = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid_w%0d", WS[k]), {31'h0, o_valid[k]}, 32'h0);
      chk($sformatf("rst_ready_w%0d", WS[k]), {31'h0, o_ready[k]}, 32'h0);
      chk($sformatf("rst_out_w%0d", WS[k]), o_out[k], 32'h0);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Seed 1, held request: WARMUP=0 and WARMUP=2 streams.
    seed = 32'h1;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 1'b1;
    wq0.delete();
    wq2.delete();
    tick();
    chk("t1_ready_w0", {31'h0, o_ready[0]}, 32'h1);
    chk("t2_ready_w2_early", {31'h0, o_ready[1]}, 32'h0);
    tick();
    chk("t2_ready_w2_third_edge", {31'h0, o_ready[1]}, 32'h1);
    for (int i = 0; i < 16 && (wq0.size() < 3 || wq2.size() < 2); i++) tick();
    req = 1'b0;
    chk("t1_word0", wq0[0], 32'h00000001);
    chk("t1_word1", wq0[1], 32'h80200003);
    chk("t1_word2", wq0[2], 32'hC0300002);
    chk("t2_word0", wq2[0], 32'hC0300002);
    chk("t2_word1", wq2[1], 32'h60180001);
    tick();

    // Entropy bit mixed into the first word's step.
    seed = 32'h1;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 1'b1;
    wq0.delete();
    tick();
    ev = 1'b1;
    eb = 1'b1;
    tick();
    ev = 1'b0;
    eb = 1'b0;
    tick();
    req = 1'b0;
    chk("t4_word0", wq0[0], 32'h00000001);
    chk("t4_word1", wq0[1], 32'h00200003);
    tick();

    // Zero seed is the same as SEED.
    run_seed("t3_zero", 32'h0, 4);
    run_seed("t3_seed", SEED, 4);

    // seed_load colliding with a held request in RUN.
    req = 1'b1;
    tick();
    tick();
    run_seed("t5", $urandom | 32'h1, 3);

    // Asynchronous reset while words are streaming.
    req = 1'b1;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t6_valid_w%0d", WS[k]), {31'h0, o_valid[k]}, 32'h0);
      chk($sformatf("t6_ready_w%0d", WS[k]), {31'h0, o_ready[k]}, 32'h0);
      chk($sformatf("t6_out_w%0d", WS[k]), o_out[k], 32'h0);
    end
    tick();
    tick();
    rst = 1'b0;
    wq16.delete();
    for (int i = 0; i < 64 && wq16.size() < 3; i++) tick();
    req = 1'b0;
    begin
      logic [31:0] r;
      r = SEED;
      for (int i = 0; i < 16; i++) r = nstep(r, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t6_cold_word%0d", i), wq16[i], r);
        r = nstep(r, 1'b0, 1'b0);
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      seed_load = ($urandom_range(39) == 0);
      seed      = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      ev        = $urandom_range(1) == 1;
      eb        = $urandom_range(1) == 1;
      req       = ($urandom_range(3) != 0);
      tick();
    end
    seed_load = 1'b0;
    req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
